ori_hist_acc: RTL and testbench

ORI_HIST_ACC -- requirements
Module: ori_hist_acc

---
 rtl/ori_hist_pkg.sv | 22 ++
 rtl/ori_peak_scan.sv | 49 ++++
 rtl/ori_hist_acc.sv | 107 ++++++++++
 tb/tb_ori_hist_acc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ori_hist_pkg.sv
// Shared defaults, FSM state type and direction-code-to-bin mapping for the
// orientation histogram accumulator.
package ori_hist_pkg;

   localparam int DEF_NBIN = 32;
   localparam int DEF_MAGW = 8;
   localparam int DEF_ACCW = 16;
   localparam int BINW     = 5;

   typedef enum logic [1:0] {
      ST_CLR  = 2'd0,
      ST_ACC  = 2'd1,
      ST_SCAN = 2'd2,
      ST_OUT  = 2'd3
   } state_e;

   // Offset-binary view of the signed code: -16 -> 0, 0 -> 16, 15 -> 31.
   function automatic logic [BINW-1:0] dir_to_bin(input logic [BINW-1:0] dir);
      return {~dir[BINW-1], dir[BINW-2:0]};
   endfunction

endpackage

// File: rtl/ori_peak_scan.sv
// Sequential argmax over the histogram: one bin per enabled cycle, lowest index
// wins ties because the running maximum only moves on a strictly greater bin.
module ori_peak_scan
   import ori_hist_pkg::*;
#(
   parameter int NBIN = DEF_NBIN,
   parameter int ACCW = DEF_ACCW
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr_i,
   input  logic            en_i,
   input  logic [ACCW-1:0] bin_val_i,
   output logic [BINW-1:0] idx_o,
   output logic            last_o,
   output logic [ACCW-1:0] res_val_o,
   output logic [BINW-1:0] res_idx_o
);

   logic [BINW-1:0] idx_q;
   logic [ACCW-1:0] max_q;
   logic [BINW-1:0] arg_q;
   logic            take;

   assign take      = en_i && (bin_val_i > max_q);
   assign last_o    = en_i && (idx_q == BINW'(NBIN - 1));
   assign idx_o     = idx_q;
   // Result including the bin examined this cycle, so the final scan cycle's
   // comparison is visible to the caller without an extra cycle.
   assign res_val_o = take ? bin_val_i : max_q;
   assign res_idx_o = take ? idx_q : arg_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         max_q <= '0;
         arg_q <= '0;
      end else if (clr_i) begin
         idx_q <= '0;
         max_q <= '0;
         arg_q <= '0;
      end else if (en_i) begin
         idx_q <= last_o ? '0 : idx_q + 1'b1;
         max_q <= res_val_o;
         arg_q <= res_idx_o;
      end
   end

endmodule

// File: rtl/ori_hist_acc.sv
// Orientation histogram accumulator: bins weighted samples of one keypoint
// window, scans for the dominant bin and presents it on a valid/ready port.
module ori_hist_acc
   import ori_hist_pkg::*;
#(
   parameter int NBIN = DEF_NBIN,
   parameter int MAGW = DEF_MAGW,
   parameter int ACCW = DEF_ACCW
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [4:0]      s_dir,
   input  logic [MAGW-1:0] s_mag,
   input  logic            s_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [4:0]      m_bin,
   output logic [ACCW-1:0] m_peak,
   output logic            busy,
   output state_e          dbg_state
);

   // Both ports are valid/ready: a transfer happens on the rising edge where
   // valid && ready; the producer holds its payload until then.
   state_e          state_q, state_d;
   logic [ACCW-1:0] bin_q [NBIN];
   logic            accept;
   logic [BINW-1:0] acc_idx;
   logic [ACCW:0]   acc_sum;
   logic [ACCW-1:0] acc_new;
   logic [BINW-1:0] scan_idx;
   logic            scan_last;
   logic [ACCW-1:0] res_val;
   logic [BINW-1:0] res_idx;
   logic [BINW-1:0] m_bin_q;
   logic [ACCW-1:0] m_peak_q;

   assign s_ready   = (state_q == ST_ACC);
   assign m_valid   = (state_q == ST_OUT);
   assign busy      = (state_q != ST_ACC);
   assign m_bin     = m_bin_q;
   assign m_peak    = m_peak_q;
   assign dbg_state = state_q;

   assign accept  = s_valid && s_ready;
   assign acc_idx = dir_to_bin(s_dir);
   assign acc_sum = {1'b0, bin_q[acc_idx]} + (ACCW+1)'(s_mag);
   assign acc_new = acc_sum[ACCW] ? '1 : acc_sum[ACCW-1:0];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLR:  state_d = ST_ACC;
         ST_ACC:  if (accept && s_last) state_d = ST_SCAN;
         ST_SCAN: if (scan_last) state_d = ST_OUT;
         ST_OUT:  if (m_ready) state_d = ST_CLR;
         default: state_d = ST_CLR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLR;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NBIN; i++) bin_q[i] <= '0;
      end else if (state_q == ST_CLR) begin
         for (int i = 0; i < NBIN; i++) bin_q[i] <= '0;
      end else if (accept) begin
         bin_q[acc_idx] <= acc_new;
      end
   end

   ori_peak_scan #(
      .NBIN (NBIN),
      .ACCW (ACCW)
   ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q == ST_CLR),
      .en_i      (state_q == ST_SCAN),
      .bin_val_i (bin_q[scan_idx]),
      .idx_o     (scan_idx),
      .last_o    (scan_last),
      .res_val_o (res_val),
      .res_idx_o (res_idx)
   );

   // Result is captured on the final scan cycle and then frozen through OUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_bin_q  <= '0;
         m_peak_q <= '0;
      end else if (scan_last) begin
         m_bin_q  <= res_idx;
         m_peak_q <= res_val;
      end
   end

endmodule

// File: tb/tb_ori_hist_acc.sv
// Randomized self-checking bench for ori_hist_acc against an array-based
// histogram model with an expected-result queue.
module tb_ori_hist_acc;
   import ori_hist_pkg::*;

   localparam int NBIN = 32;
   localparam int MAGW = 8;
   localparam int ACCW = 16;
   localparam int SAT  = 65535;

   logic            clk = 1'b0;
   logic            rst;
   logic            s_valid;
   logic            s_ready;
   logic [4:0]      s_dir;
   logic [MAGW-1:0] s_mag;
   logic            s_last;
   logic            m_valid;
   logic            m_ready;
   logic [4:0]      m_bin;
   logic [ACCW-1:0] m_peak;
   logic            busy;
   state_e          dbg_state;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          model_bins [NBIN];
   logic [20:0] exp_q [$];
   int          win_dir [$];
   int          win_mag [$];

   ori_hist_acc #(.NBIN(NBIN), .MAGW(MAGW), .ACCW(ACCW)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_dir     (s_dir),
      .s_mag     (s_mag),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_bin     (m_bin),
      .m_peak    (m_peak),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < NBIN; i++) model_bins[i] = 0;
   endtask

   task automatic model_add(input int dir, input int mag);
      int b;
      b = dir + 16;
      model_bins[b] = model_bins[b] + mag;
      if (model_bins[b] > SAT) model_bins[b] = SAT;
   endtask

   task automatic model_close();
      int best;
      int bi;
      best = 0;
      bi   = 0;
      for (int i = 0; i < NBIN; i++) begin
         if (model_bins[i] > best) begin
            best = model_bins[i];
            bi   = i;
         end
      end
      exp_q.push_back({5'(bi), 16'(best)});
      model_clear();
   endtask

   task automatic send_samples(input int max_gap);
      int n;
      int gap;
      n = win_dir.size();
      for (int i = 0; i < n; i++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_dir   = 5'($urandom);
            s_mag   = MAGW'($urandom);
            s_last  = 1'($urandom);
            tick();
         end
         s_valid = 1'b1;
         s_dir   = 5'(win_dir[i]);
         s_mag   = MAGW'(win_mag[i]);
         s_last  = (i == n - 1);
         check_eq("acc_ready", 32'(s_ready), 32'd1);
         if (i == 0) check_eq("acc_busy", 32'(busy), 32'd0);
         model_add(win_dir[i], win_mag[i]);
         tick();
      end
      model_close();
      win_dir.delete();
      win_mag.delete();
   endtask

   // Keeps s_valid asserted with junk through SCAN; none of it may be taken.
   task automatic await_result();
      int n;
      n = 0;
      check_eq("mvalid_early", 32'(m_valid), 32'd0);
      while (!m_valid && n < 200) begin
         s_valid = 1'b1;
         s_dir   = 5'($urandom);
         s_mag   = MAGW'($urandom);
         s_last  = 1'($urandom);
         if (n > 0) check_eq("scan_ready", 32'(s_ready), 32'd0);
         tick();
         n++;
      end
      check_eq("latency", 32'(n), 32'(NBIN));
   endtask

   task automatic take_result(input int hold);
      logic [20:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 21'h1FFFFF;
      check_eq("m_valid", 32'(m_valid), 32'd1);
      check_eq("m_bin", 32'(m_bin), 32'(e[20:16]));
      check_eq("m_peak", 32'(m_peak), 32'(e[15:0]));
      for (int h = 0; h < hold; h++) begin
         m_ready = 1'b0;
         s_valid = 1'b1;
         s_dir   = 5'($urandom);
         s_mag   = MAGW'($urandom);
         tick();
         check_eq("hold_valid", 32'(m_valid), 32'd1);
         check_eq("hold_bin", 32'(m_bin), 32'(e[20:16]));
         check_eq("hold_peak", 32'(m_peak), 32'(e[15:0]));
         check_eq("hold_ready", 32'(s_ready), 32'd0);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      check_eq("clr_ready", 32'(s_ready), 32'd0);
      check_eq("clr_valid", 32'(m_valid), 32'd0);
      check_eq("clr_busy", 32'(busy), 32'd1);
      tick();
      check_eq("ready_2cyc", 32'(s_ready), 32'd1);
   endtask

   task automatic add_sample(input int dir, input int mag);
      win_dir.push_back(dir);
      win_mag.push_back(mag);
   endtask

   initial begin
      int saw_valid;
      int nsamp;
      rst     = 1'b1;
      s_valid = 1'b0;
      s_dir   = '0;
      s_mag   = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      model_clear();
      repeat (3) tick();
      check_eq("rst_ready", 32'(s_ready), 32'd0);
      check_eq("rst_mvalid", 32'(m_valid), 32'd0);
      check_eq("rst_mbin", 32'(m_bin), 32'd0);
      check_eq("rst_mpeak", 32'(m_peak), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      check_eq("post_rst_clr", 32'(s_ready), 32'd0);
      tick();
      check_eq("post_rst_ready", 32'(s_ready), 32'd1);

      // Majority bin 16 from two same-bin samples.
      add_sample(0, 10); add_sample(0, 20); add_sample(5, 7);
      send_samples(0);
      await_result();
      take_result(3);

      // Tie between the lowest and highest bins, then a long backpressure hold.
      add_sample(-16, 50); add_sample(15, 50);
      send_samples(1);
      await_result();
      take_result(20);

      // Saturation with back-to-back samples into one bin.
      for (int i = 0; i < 300; i++) add_sample(-8, 255);
      send_samples(0);
      await_result();
      take_result(0);

      // Empty histogram.
      add_sample(5, 0);
      send_samples(0);
      await_result();
      take_result(1);

      // Reset during scan cycle 10 discards the window.
      add_sample(7, 200); add_sample(-3, 100);
      send_samples(0);
      repeat (10) tick();
      void'(exp_q.pop_back());
      s_valid = 1'b0;
      rst     = 1'b1;
      #1;
      check_eq("mid_rst_mvalid", 32'(m_valid), 32'd0);
      check_eq("mid_rst_mbin", 32'(m_bin), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd1);
      tick();
      rst = 1'b0;
      check_eq("mid_rst_clr", 32'(s_ready), 32'd0);
      saw_valid = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_valid) saw_valid++;
      end
      check_eq("no_stale_valid", 32'(saw_valid), 32'd0);
      add_sample(3, 9);
      send_samples(0);
      await_result();
      take_result(2);

      // Random windows with idle gaps.
      for (int w = 0; w < 8; w++) begin
         nsamp = int'($urandom_range(40, 1));
         for (int i = 0; i < nsamp; i++)
            add_sample(int'($urandom_range(31, 0)) - 16, int'($urandom_range(255, 0)));
         send_samples(3);
         await_result();
         take_result(int'($urandom_range(5, 0)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
